// File: rtl/exe_stage.sv
// Execute stage: ALU, branch resolve, optional iterative mul/div.
// Define EXE_MULDIV_EN to build in the radix-2 mul/div unit and its FSM.
module exe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       EXE_Cmd,
  input  logic [1:0]       BR_Type,
  input  logic [WIDTH-1:0] readdata1,
  input  logic [WIDTH-1:0] readdata2,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] Immediate,
  input  logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] st_val,
  output logic             br_taken,
  output logic [WIDTH-1:0] br_addr,
  output logic             exe_stall
);

  logic [WIDTH-1:0] w_val1;
  logic [WIDTH-1:0] w_val2;
  logic [4:0]       w_shamt;
  logic [WIDTH-1:0] w_alu;
  logic             w_br_cond;

  assign w_val1  = readdata1;
  assign w_val2  = data2;
  assign w_shamt = data2[4:0];

  always_comb begin
    w_alu = '0;
    unique casez (EXE_Cmd)
      4'b0000: w_alu = w_val1 + w_val2;
      4'b0001: w_alu = w_val1 - w_val2;
      4'b0010: w_alu = w_val1 & w_val2;
      4'b0011: w_alu = w_val1 | w_val2;
      4'b0100: w_alu = ~(w_val1 | w_val2);
      4'b0101: w_alu = w_val1 ^ w_val2;
      4'b0110: w_alu = w_val1 << w_shamt;
      4'b0111: w_alu = WIDTH'($signed(w_val1) >>> w_shamt);
      4'b1000: w_alu = w_val1 >> w_shamt;
      4'b1001,
      4'b1010,
      4'b1011: w_alu = '0;
      4'b11??: w_alu = w_val2;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_br_cond = 1'b0;
    unique case (BR_Type)
      2'b00: w_br_cond = 1'b0;
      2'b01: w_br_cond = (readdata1 == '0);
      2'b10: w_br_cond = (readdata1 != readdata2);
      2'b11: w_br_cond = 1'b1;
      default: w_br_cond = 1'b0;
    endcase
  end

  assign st_val   = readdata2;
  assign br_addr  = PC + (Immediate << 2);
  assign br_taken = w_br_cond & ~exe_stall;

`ifdef EXE_MULDIV_EN

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_BUSY = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;

  logic             w_is_md;
  logic             w_is_mul;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_md_res;

  assign w_is_md  = (EXE_Cmd == 4'b1001) |
                    (EXE_Cmd == 4'b1010) |
                    (EXE_Cmd == 4'b1011);
  assign w_is_mul = (EXE_Cmd == 4'b1001);

  // div: r_a divisor, r_b dividend->quotient, r_acc remainder
  assign w_rem_sh = {r_acc, r_b[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_a};
  assign w_ge     = ~w_diff[WIDTH];
  assign w_md_res = (r_op == OP_DIV) ? r_b : r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_is_md) begin
            r_op    <= EXE_Cmd[1:0];
            r_a     <= w_is_mul ? w_val1 : w_val2;
            r_b     <= w_is_mul ? w_val2 : w_val1;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_op == OP_MUL) begin
            r_acc <= r_acc + (r_b[0] ? r_a : '0);
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
          end else if (w_ge) begin
            r_acc <= w_diff[WIDTH-1:0];
            r_b   <= {r_b[WIDTH-2:0], 1'b1};
          end else begin
            r_acc <= w_rem_sh[WIDTH-1:0];
            r_b   <= {r_b[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1))
            r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // reset also drops stall so a held muldiv command cannot reassert it
  assign exe_stall  = ~rst &
                      (((r_state == S_IDLE) & w_is_md) |
                       (r_state == S_BUSY));
  assign alu_result = (r_state == S_DONE) ? w_md_res : w_alu;

`else

  logic w_unused;

  assign w_unused   = &{1'b0, clk, rst};
  assign exe_stall  = 1'b0;
  assign alu_result = w_alu;

`endif

endmodule

// File: tb/tb_exe_stage.sv
// Testbench for exe_stage: vector table, random ALU/branch,
// and mul/div timing sequences when EXE_MULDIV_EN is defined.
module tb_exe_stage;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [3:0]   cmd;
  logic [1:0]   brt;
  logic [W-1:0] rd1;
  logic [W-1:0] rd2;
  logic [W-1:0] d2;
  logic [W-1:0] imm;
  logic [W-1:0] pc;
  logic [W-1:0] alu_result;
  logic [W-1:0] st_val;
  logic         br_taken;
  logic [W-1:0] br_addr;
  logic         exe_stall;

  int n_tests = 0;
  int n_fail  = 0;

  exe_stage #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .EXE_Cmd    (cmd),
    .BR_Type    (brt),
    .readdata1  (rd1),
    .readdata2  (rd2),
    .data2      (d2),
    .Immediate  (imm),
    .PC         (pc),
    .alu_result (alu_result),
    .st_val     (st_val),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .exe_stall  (exe_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   cmd;
    logic [1:0]   brt;
    logic [W-1:0] v1;
    logic [W-1:0] r2;
    logic [W-1:0] v2;
    logic [W-1:0] imm;
    logic [W-1:0] pc;
    logic [W-1:0] e_alu;
    logic         e_br;
    logic [W-1:0] e_addr;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string nm,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] b,
                       input logic [W-1:0] a1, input logic [W-1:0] a2,
                       input logic [W-1:0] v2, input logic [W-1:0] im,
                       input logic [W-1:0] p);
    cmd = c; brt = b; rd1 = a1; rd2 = a2;
    d2 = v2; imm = im; pc = p;
  endtask

  // reference ALU from the operation table
  function automatic logic [W-1:0] ref_alu(input logic [3:0] c,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int sh;
    longint sa;
    sh = int'(b[4:0]);
    sa = longint'($signed(a));
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return ~(a | b);
      4'd5: return a ^ b;
      4'd6: return a << sh;
      4'd7: return W'(sa / (longint'(1) << sh) -
                      ((sa < 0 && (sa % (longint'(1) << sh)) != 0)
                       ? 1 : 0));
      4'd8: return a >> sh;
      4'd9, 4'd10, 4'd11: return '0;
      default: return b;
    endcase
  endfunction

  function automatic logic ref_br(input logic [1:0] b,
                                  input logic [W-1:0] a,
                                  input logic [W-1:0] s);
    case (b)
      2'd1: return a == 0;
      2'd2: return a != s;
      2'd3: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

`ifdef EXE_MULDIV_EN
  function automatic logic [W-1:0] ref_md(input logic [3:0] c,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = a * b;
    if (c == 4'd9) return p[W-1:0];
    if (c == 4'd10) return (b == 0) ? {W{1'b1}} : a / b;
    return (b == 0) ? a : a % b;
  endfunction

  task automatic run_md(input string nm, input logic [3:0] c,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    logic [W-1:0] exp;
    exp = ref_md(c, a, b);
    @(negedge clk);
    drive(c, 2'b11, a, 32'h0, b, 32'h0, 32'h0);
    #1;
    check({nm, "_brmask"}, {31'b0, br_taken}, 32'd0);
    n = 0;
    while (exe_stall === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({nm, "_stallcyc"}, n, W + 1);
    check({nm, "_res"}, alu_result, exp);
  endtask
`endif

  initial begin
    logic [3:0]   c;
    logic [1:0]   b;
    logic [W-1:0] a1, a2, v2, im, p;

    rst = 1'b1;
    drive(4'd0, 2'd0, '0, '0, '0, '0, '0);
    #1;
    check("rst_alu", alu_result, '0);
    check("rst_st", st_val, '0);
    check("rst_br", {31'b0, br_taken}, '0);
    check("rst_addr", br_addr, '0);
    check("rst_stall", {31'b0, exe_stall}, '0);
    @(negedge clk);
    rst = 1'b0;

    vt.push_back('{4'd0, 2'd0, 32'h7FFFFFFF, 0, 1, 0, 0,
                   32'h80000000, 0, 0});
    vt.push_back('{4'd1, 2'd0, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 0, 0});
    vt.push_back('{4'd2, 2'd0, 32'hF0F0, 0, 32'hFF00, 0, 0,
                   32'hF000, 0, 0});
    vt.push_back('{4'd4, 2'd0, 32'hF0F0, 0, 32'h0F0F, 0, 0,
                   32'hFFFF0000, 0, 0});
    vt.push_back('{4'd6, 2'd0, 1, 0, 32'h3F, 0, 0,
                   32'h80000000, 0, 0});
    vt.push_back('{4'd7, 2'd0, 32'h80000000, 0, 4, 0, 0,
                   32'hF8000000, 0, 0});
    vt.push_back('{4'd8, 2'd0, 32'h80000000, 0, 4, 0, 0,
                   32'h08000000, 0, 0});
    vt.push_back('{4'd13, 2'd0, 5, 0, 32'hABCD, 0, 0,
                   32'hABCD, 0, 0});
    vt.push_back('{4'd0, 2'd2, 5, 6, 0, 3, 32'h100,
                   5, 1, 32'h10C});
    vt.push_back('{4'd0, 2'd2, 5, 5, 0, 3, 32'h100,
                   5, 0, 32'h10C});
    vt.push_back('{4'd0, 2'd1, 0, 7, 0, 32'hFFFFFFFF, 32'h100,
                   0, 1, 32'hFC});
    vt.push_back('{4'd0, 2'd3, 1, 1, 1, 0, 32'h40,
                   2, 1, 32'h40});

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive(vt[i].cmd, vt[i].brt, vt[i].v1, vt[i].r2,
            vt[i].v2, vt[i].imm, vt[i].pc);
      #1;
      check($sformatf("vec%0d_alu", i), alu_result, vt[i].e_alu);
      check($sformatf("vec%0d_br", i), {31'b0, br_taken},
            {31'b0, vt[i].e_br});
      check($sformatf("vec%0d_addr", i), br_addr, vt[i].e_addr);
      check($sformatf("vec%0d_st", i), st_val, vt[i].r2);
      check($sformatf("vec%0d_stall", i), {31'b0, exe_stall}, '0);
    end

    for (int i = 0; i < 200; i++) begin
      c = 4'($urandom_range(0, 12));
      if (c >= 4'd9) c = c + 4'd3;
      b  = 2'($urandom_range(0, 3));
      a1 = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      a2 = ($urandom_range(0, 2) == 0) ? a1 : $urandom;
      v2 = $urandom;
      im = $urandom;
      p  = $urandom;
      @(negedge clk);
      drive(c, b, a1, a2, v2, im, p);
      #1;
      check($sformatf("rnd%0d_alu", i), alu_result,
            ref_alu(c, a1, v2));
      check($sformatf("rnd%0d_br", i), {31'b0, br_taken},
            {31'b0, ref_br(b, a1, a2)});
      check($sformatf("rnd%0d_addr", i), br_addr, p + im * 4);
    end

`ifdef EXE_MULDIV_EN
    run_md("mul_tp", 4'd9, 32'h00010003, 32'h00020005);
    run_md("div_tp", 4'd10, 100, 7);
    run_md("rem_tp", 4'd11, 100, 7);
    run_md("div0", 4'd10, 9, 0);
    run_md("rem0", 4'd11, 9, 0);
    for (int i = 0; i < 6; i++) begin
      c = 4'($urandom_range(9, 11));
      a1 = $urandom;
      v2 = (i == 5) ? '0 : $urandom >> $urandom_range(0, 31);
      run_md($sformatf("mdrnd%0d", i), c, a1, v2);
    end

    @(negedge clk);
    drive(4'd9, 2'd0, 7, 0, 9, 0, 0);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy_stall", {31'b0, exe_stall}, '0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'd0, 2'd0, 2, 0, 2, 0, 0);
    #1;
    check("post_rst_add", alu_result, 4);
    check("post_rst_stall", {31'b0, exe_stall}, '0);
    @(negedge clk);
    #1;
    check("post_rst_idle", {31'b0, exe_stall}, '0);
`else
    begin
      int seen;
      seen = 0;
      @(negedge clk);
      drive(4'd9, 2'd0, 3, 0, 4, 0, 0);
      for (int i = 0; i < 40; i++) begin
        #1;
        if (exe_stall !== 1'b0) seen++;
        @(negedge clk);
      end
      check("nomd_mul_res", alu_result, '0);
      check("nomd_stall_seen", seen, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage MIPS-style pipeline. It consumes the ID/EX pipeline register outputs and computes the ALU result, the store value and the branch decision/target for the EX/MEM register. Single-cycle ALU operations complete combinationally. MUL/DIV/REM run on an iterative radix-2 unit, which stalls the front of the pipeline until the result is ready.

## Interface
Parameters:
- WIDTH, 32, datapath width; iteration count of the mul/div unit equals WIDTH.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- EXE_Cmd  in  4  operation from ID/EX.
- BR_Type  in  2  00 none, 01 BEZ (val1==0), 10 BNE (val1!=st_val), 11 JMP.
- readdata1  in  WIDTH  operand val1.
- readdata2  in  WIDTH  register rt value; driven unchanged to st_val.
- data2  in  WIDTH  operand val2 (reg/imm already muxed upstream).
- Immediate  in  WIDTH  sign-extended branch offset.
- PC  in  WIDTH  PC+4 of the instruction.
- alu_result  out  WIDTH  result for EX/MEM.
- st_val  out  WIDTH  store data (=readdata2).
- br_taken  out  1  branch/jump taken; flushes IF/ID.
- br_addr  out  WIDTH  PC + (Immediate<<2).
- exe_stall  out  1  freeze PC, IF/ID, ID/EX; bubble EX/MEM.

## Operation
- EXE_Cmd: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 NOR, 0101 XOR, 0110 SLL, 0111 SRA, 1000 SRL, 1001 MUL, 1010 DIV, 1011 REM, 11xx pass val2.
- Shift amount is val2[4:0]. ADD/SUB wrap modulo 2^WIDTH with no overflow flag.
- MUL returns the low WIDTH bits of the product. DIV and REM are unsigned.
- Divide by zero: DIV returns all ones; REM returns val1.
- br_taken is combinational from BR_Type and operands. It is forced 0 while exe_stall=1.
- Mul/div FSM states: IDLE, BUSY, DONE.
  - IDLE: on a MUL/DIV/REM command, exe_stall=1 combinationally. At the clock edge, latch the operands and op, clear the counter, and go to BUSY.
  - BUSY: perform one shift-add (mul) or restoring-subtract (div) step per cycle, with exe_stall=1. When the counter reaches WIDTH-1, go to DONE.
  - DONE: exe_stall=0, and alu_result is the latched mul/div result. Go to IDLE on the next edge. A new command is never accepted in DONE; the held instruction advances at this edge.
- In IDLE with a non-muldiv command, alu_result is the combinational ALU output.

## Timing
- Single-cycle operations: zero added latency.
- MUL/DIV/REM:
  - Issue cycle plus WIDTH BUSY cycles give exe_stall high for WIDTH+1 cycles.
  - The result is valid in the following DONE cycle, WIDTH+2 cycles after issue, and is captured by EX/MEM at the end of it.
- Back-to-back muldiv: the second command is issued in the cycle after DONE, with no idle gap beyond that.
- Reset (async, any state):
  - FSM goes to IDLE; counter and operand/result registers go to 0; exe_stall goes to 0 immediately.
  - Reset mid-BUSY abandons the operation.
- With ID/EX inputs all zero, as after reset: alu_result=0, st_val=0, br_taken=0, br_addr=0.

## Configuration
- EXE_MULDIV_EN defined: the mul/div unit and FSM are compiled in, as above.
- EXE_MULDIV_EN undefined:
  - No FSM and no sequential logic.
  - Commands 1001–1011 return 0.
  - exe_stall is tied 0.

## Test plan
- ADD val1=0x7FFFFFFF, val2=1 -> alu_result=0x80000000, exe_stall=0.
- BNE with val1=5, st_val=6, PC=0x100, Immediate=3 -> br_taken=1, br_addr=0x10C. Repeat with st_val=5 -> br_taken=0.
- MUL 0x0001_0003 × 0x0002_0005 -> exe_stall high 33 cycles, then one DONE cycle with alu_result=0x000B_000F.
- DIV 100/7 -> 14; REM 100/7 -> 2; DIV 9/0 -> 0xFFFFFFFF; REM 9/0 -> 9.
- Assert rst asynchronously in BUSY cycle 10 -> exe_stall falls with no clock edge. After release, ADD 2+2 -> 4.
- Build without EXE_MULDIV_EN, issue MUL 3×4 -> alu_result=0, exe_stall never asserted.
